adder_accumulator: RTL and testbench



---
 rtl/adder_accumulator_pkg.sv | 24 ++
 rtl/adder_accumulator_settle_timer.sv | 30 +++
 rtl/adder_accumulator.sv | 116 +++++++++++
 tb/tb_adder_accumulator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_accumulator_pkg.sv
// rtl/adder_accumulator_pkg.sv - shared constants, state encoding and overflow helper for adder_accumulator
package adder_accumulator_pkg;

  localparam int DATA_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_RESULT = 2'd2;

  localparam logic [DATA_W-1:0] SAT_POS = 4'b0111;
  localparam logic [DATA_W-1:0] SAT_NEG = 4'b1000;

  localparam logic [3:0] COUNT_MAX = 4'd15;

  // Signed overflow of a + b = s: operands agree in sign and the sum disagrees.
  function automatic logic signed_ovf(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b,
                                      input logic [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

endpackage

// File: rtl/adder_accumulator_settle_timer.sv
// rtl/adder_accumulator_settle_timer.sv - loadable down-counter with zero flag timing the adder settle window
module settle_timer #(
  parameter int SETTLE_CYCLES = 6,
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Load on operand acceptance, then count down to zero while settling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - operand sequencer/accumulator around an external ripple adder; optional SATURATE_EN clamps on overflow
module adder_accumulator
  import adder_accumulator_pkg::*;
#(
  parameter int SETTLE_CYCLES = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_data,
  input  logic              op_last,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_sum,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_sum,
  output logic              result_overflow,
  output logic [3:0]        result_count
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b_q;
  logic              last_q;
  logic              ovf_sticky;
  logic [3:0]        count;

  logic              accept;
  logic              capture;
  logic              release_res;
  logic              timer_zero;
  logic              ovf;
  logic [DATA_W-1:0] acc_next;

  assign accept      = (state == ST_IDLE) && op_valid;
  assign capture     = (state == ST_SETTLE) && timer_zero;
  assign release_res = (state == ST_RESULT) && result_ready;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .dec     (state == ST_SETTLE),
    .zero    (timer_zero)
  );

  // Overflow is judged from the adder's operands and sum, not from any adder flag.
  assign ovf = signed_ovf(acc, b_q, add_sum);

`ifdef SATURATE_EN
  // Clamp toward the sign of the running total when the add overflows.
  always_comb begin
    acc_next = add_sum;
    if (ovf) begin
      acc_next = acc[DATA_W-1] ? SAT_NEG : SAT_POS;
    end
  end
`else
  // Plain modulo-16 wrap.
  always_comb begin
    acc_next = add_sum;
  end
`endif

  // Sequencer: accept operand, hold adder inputs through settle, capture, report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      acc        <= '0;
      b_q        <= '0;
      last_q     <= 1'b0;
      ovf_sticky <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            b_q    <= op_data;
            last_q <= op_last;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (capture) begin
            acc        <= acc_next;
            ovf_sticky <= ovf_sticky | ovf;
            count      <= (count == COUNT_MAX) ? COUNT_MAX : count + 4'd1;
            state      <= last_q ? ST_RESULT : ST_IDLE;
          end
        end
        ST_RESULT: begin
          if (release_res) begin
            acc        <= '0;
            ovf_sticky <= 1'b0;
            count      <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign op_ready        = (state == ST_IDLE);
  assign result_valid    = (state == ST_RESULT);
  assign add_a           = acc;
  assign add_b           = b_q;
  assign result_sum      = acc;
  assign result_overflow = ovf_sticky;
  assign result_count    = count;

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - scoreboard bench for adder_accumulator with a behavioural adder
module tb_adder_accumulator;

  localparam int SETTLE = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_data = '0;
  logic       op_last = 1'b0;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic [3:0] result_sum;
  logic       result_overflow;
  logic [3:0] result_count;

  typedef struct {
    logic [3:0] sum;
    logic       ovf;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  logic [3:0] ops [0:31];

  logic [3:0] m_acc = '0;
  logic       m_ovf = 1'b0;
  logic [3:0] m_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal adder standing in for the external ripple chain.
  assign add_sum = add_a + add_b;

  adder_accumulator #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_data         (op_data),
    .op_last         (op_last),
    .add_a           (add_a),
    .add_b           (add_b),
    .add_sum         (add_sum),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_sum      (result_sum),
    .result_overflow (result_overflow),
    .result_count    (result_count)
  );

  task automatic model_add(input logic [3:0] op);
    int s;
    bit o;
    s = int'($signed(m_acc)) + int'($signed(op));
    o = (s > 7) || (s < -8);
`ifdef SATURATE_EN
    if (o) m_acc = (s > 7) ? 4'd7 : 4'd8;
    else   m_acc = 4'(s);
`else
    m_acc = 4'(s);
`endif
    m_ovf = m_ovf | o;
    m_cnt = (m_cnt == 4'd15) ? 4'd15 : m_cnt + 4'd1;
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  task automatic drive_group(input int n, input bit check_gap, input bit push);
    int   waited;
    int   prev;
    exp_t e;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op_valid = 1'b1;
      op_data  = ops[i];
      op_last  = (i == n - 1);
      waited = 0;
      while (!op_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!op_ready) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout op %0d: op_ready stayed %b, required 1", i, op_ready);
        op_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
      model_add(ops[i]);
      if (check_gap && i > 0) begin
        checks++;
        if ((last_acc_cyc - prev) !== SETTLE + 1) begin
          errors++;
          $display("FAIL accept_gap op %0d: gap %0d, required %0d", i, last_acc_cyc - prev, SETTLE + 1);
        end
      end
      prev = last_acc_cyc;
    end
    op_valid = 1'b0;
    op_last  = 1'b0;
    if (push) begin
      e.sum = m_acc;
      e.ovf = m_ovf;
      e.cnt = m_cnt;
      sb.push_back(e);
    end
    model_clear();
  endtask

  task automatic wait_result(input int hold);
    int   waited;
    exp_t e;
    logic [3:0] s0;
    logic       o0;
    logic [3:0] c0;
    waited = 0;
    @(negedge clk);
    while (!result_valid && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!result_valid) begin
      errors++;
      $display("FAIL result_timeout: result_valid %b, required 1", result_valid);
      return;
    end
    checks++;
    if ((cyc - last_acc_cyc) !== SETTLE) begin
      errors++;
      $display("FAIL result_latency: %0d cycles, required %0d", cyc - last_acc_cyc, SETTLE);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: result with no expectation queued");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (result_sum !== e.sum) begin
      errors++;
      $display("FAIL result_sum: got %b, required %b", result_sum, e.sum);
    end
    checks++;
    if (result_overflow !== e.ovf) begin
      errors++;
      $display("FAIL result_overflow: got %b, required %b", result_overflow, e.ovf);
    end
    checks++;
    if (result_count !== e.cnt) begin
      errors++;
      $display("FAIL result_count: got %0d, required %0d", result_count, e.cnt);
    end
    s0 = result_sum;
    o0 = result_overflow;
    c0 = result_count;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || op_ready !== 1'b0 || result_sum !== s0 ||
          result_overflow !== o0 || result_count !== c0) begin
        errors++;
        $display("FAIL result_hold cycle %0d: valid %b ready %b sum %b ovf %b cnt %0d, required 1 0 %b %b %0d",
                 h, result_valid, op_ready, result_sum, result_overflow, result_count, s0, o0, c0);
      end
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    checks++;
    if (op_ready !== 1'b1 || result_valid !== 1'b0 || result_sum !== 4'd0 ||
        result_overflow !== 1'b0 || result_count !== 4'd0) begin
      errors++;
      $display("FAIL result_release: ready %b valid %b sum %b ovf %b cnt %0d, required 1 0 0000 0 0",
               op_ready, result_valid, result_sum, result_overflow, result_count);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b, required 1", op_ready); end
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b, required 0", result_valid); end
    checks++;
    if (add_a !== 4'd0 || add_b !== 4'd0) begin
      errors++; $display("FAIL reset_add_ab: got %b %b, required 0000 0000", add_a, add_b);
    end
    checks++;
    if (result_sum !== 4'd0 || result_overflow !== 1'b0 || result_count !== 4'd0) begin
      errors++; $display("FAIL reset_result: got %b %b %0d, required 0000 0 0", result_sum, result_overflow, result_count);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    ops[0] = 4'd3; ops[1] = 4'd4;
    drive_group(2, 1'b1, 1'b1);
    wait_result(0);
  endtask

  task automatic test_overflow();
    ops[0] = 4'd5; ops[1] = 4'd4;
    drive_group(2, 1'b0, 1'b1);
    wait_result(0);
    ops[0] = 4'b1000; ops[1] = 4'b1111;
    drive_group(2, 1'b0, 1'b1);
    wait_result(0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++) ops[i] = 4'd0;
    drive_group(17, 1'b1, 1'b1);
    wait_result(0);
  endtask

  task automatic test_hold();
    ops[0] = 4'd6; ops[1] = 4'b1101;
    drive_group(2, 1'b0, 1'b1);
    wait_result(10);
    ops[0] = 4'd2;
    drive_group(1, 1'b0, 1'b1);
    wait_result(0);
  endtask

  task automatic test_reset_mid_settle();
    ops[0] = 4'd5;
    drive_group(1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1 || result_valid !== 1'b0 || add_a !== 4'd0 || add_b !== 4'd0 ||
        result_sum !== 4'd0 || result_overflow !== 1'b0 || result_count !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: ready %b valid %b a %b b %b sum %b ovf %b cnt %0d, required 1 0 0 0 0 0 0",
               op_ready, result_valid, add_a, add_b, result_sum, result_overflow, result_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || op_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: valid %b ready %b, required 0 1", i, result_valid, op_ready);
      end
    end
    ops[0] = 4'd2;
    drive_group(1, 1'b0, 1'b1);
    wait_result(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_hold();
    test_reset_mid_settle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
